// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register ids with dual alloc, dual release and sticky double-free detection
module free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  localparam int PW = $clog2(NUM_PREGS),
  localparam int CW = $clog2(NUM_PREGS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_req_1,
  input  logic          alloc_req_2,
  output logic [PW-1:0] alloc_pd_1,
  output logic [PW-1:0] alloc_pd_2,
  output logic          alloc_ok,
  input  logic          rt_flag_1,
  input  logic [PW-1:0] fp_i_1,
  input  logic          rt_flag_2,
  input  logic [PW-1:0] fp_i_2,
  output logic [CW-1:0] free_count,
  output logic          empty,
  output logic          dbl_free_err
);
  logic [PW-1:0]        fifo_q [NUM_PREGS];
  logic [PW-1:0]        head_q, tail_q;
  logic [CW-1:0]        count_q, count_d;
  logic [NUM_PREGS-1:0] fv_q, fv_d;
  logic                 err_q, ok1, ok2, bad1, bad2;
  logic [1:0]           nreq;
  assign alloc_pd_1   = fifo_q[head_q];
  assign alloc_pd_2   = fifo_q[head_q + PW'(1)];
  assign nreq         = alloc_req_1 ? (alloc_req_2 ? 2'd2 : 2'd1) : 2'd0;
  assign alloc_ok     = nreq != 2'd0 && count_q >= CW'(nreq);
  assign free_count   = count_q;
  assign empty        = count_q == '0;
  assign dbl_free_err = err_q;
  // Grants clear first so a preg granted this edge can be released on the same edge
  always_comb begin
    fv_d = fv_q;
    if (alloc_ok) fv_d[alloc_pd_1] = 1'b0;
    if (alloc_ok && alloc_req_2) fv_d[alloc_pd_2] = 1'b0;
    ok1  = rt_flag_1 && fp_i_1 != '0 && !fv_d[fp_i_1];
    bad1 = rt_flag_1 && fp_i_1 != '0 && fv_d[fp_i_1];
    if (ok1) fv_d[fp_i_1] = 1'b1;
    ok2  = rt_flag_2 && fp_i_2 != '0 && !fv_d[fp_i_2];
    bad2 = rt_flag_2 && fp_i_2 != '0 && fv_d[fp_i_2];
    if (ok2) fv_d[fp_i_2] = 1'b1;
    count_d = count_q - (alloc_ok ? CW'(nreq) : '0) + CW'(ok1) + CW'(ok2);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        fifo_q[i] <= i < NUM_PREGS - NUM_AREGS ? PW'(NUM_AREGS + i) : '0;
        fv_q[i]   <= i >= NUM_AREGS;
      end
      head_q  <= '0;
      tail_q  <= PW'(NUM_PREGS - NUM_AREGS);
      count_q <= CW'(NUM_PREGS - NUM_AREGS);
      err_q   <= 1'b0;
    end else begin
      if (ok1) fifo_q[tail_q] <= fp_i_1;
      if (ok2) fifo_q[tail_q + PW'(ok1)] <= fp_i_2;
      head_q  <= head_q + (alloc_ok ? PW'(nreq) : '0);
      tail_q  <= tail_q + PW'(ok1) + PW'(ok2);
      count_q <= count_d;
      fv_q    <= fv_d;
      err_q   <= err_q | bad1 | bad2;
    end
  end
endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed vector table plus scoreboard-driven wrap and random traffic for free_list
module tb_free_list;
  logic       clk = 1'b0, rst, alloc_req_1, alloc_req_2, rt_flag_1, rt_flag_2;
  logic [5:0] fp_i_1, fp_i_2, alloc_pd_1, alloc_pd_2;
  logic       alloc_ok, empty, dbl_free_err;
  logic [6:0] free_count;
  int         tests = 0, fails = 0;
  typedef struct {
    bit rs, r1, r2, f1, f2;
    int p1, p2, ok, pd1, pd2, cnt, emp, err;
  } vec_t;
  vec_t tv[$];
  int   q[$], held[$];

  free_list dut (
    .clk(clk), .rst(rst), .alloc_req_1(alloc_req_1), .alloc_req_2(alloc_req_2),
    .alloc_pd_1(alloc_pd_1), .alloc_pd_2(alloc_pd_2), .alloc_ok(alloc_ok),
    .rt_flag_1(rt_flag_1), .fp_i_1(fp_i_1), .rt_flag_2(rt_flag_2), .fp_i_2(fp_i_2),
    .free_count(free_count), .empty(empty), .dbl_free_err(dbl_free_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, int act, int exp);
    if (exp < 0) return;
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rs, bit r1, bit r2, bit f1, int p1, bit f2, int p2,
                              int ok, int pd1, int pd2, int cnt, int emp, int err);
    vec_t t;
    t = '{rs, r1, r2, f1, f2, p1, p2, ok, pd1, pd2, cnt, emp, err};
    return t;
  endfunction

  task automatic drive(bit rs, bit r1, bit r2, bit f1, int p1, bit f2, int p2);
    rst = rs; alloc_req_1 = r1; alloc_req_2 = r2;
    rt_flag_1 = f1; fp_i_1 = 6'(p1); rt_flag_2 = f2; fp_i_2 = 6'(p2);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    tv.push_back(mk(1, 0,0, 0,0, 0,0, -1,-1,-1,-1,-1,-1));
    tv.push_back(mk(0, 0,0, 0,0, 0,0,  0,32,33,32, 0, 0));
    tv.push_back(mk(0, 0,1, 0,0, 0,0,  0,32,33,32, 0, 0));
    tv.push_back(mk(0, 1,1, 0,0, 0,0,  1,32,33,32, 0, 0));
    tv.push_back(mk(0, 0,0, 0,0, 0,0,  0,34,35,30, 0, 0));
    for (int i = 0; i < 14; i++)
      tv.push_back(mk(0, 1,1, 0,0, 0,0, 1,34+2*i,35+2*i,30-2*i, 0, 0));
    tv.push_back(mk(0, 1,0, 0,0, 0,0,   1,62,63, 2, 0, 0));
    tv.push_back(mk(0, 1,1, 0,0, 0,0,   0,63,-1, 1, 0, 0));
    tv.push_back(mk(0, 1,0, 0,0, 0,0,   1,63,-1, 1, 0, 0));
    tv.push_back(mk(0, 1,1, 1,40, 1,41, 0,-1,-1, 0, 1, 0));
    tv.push_back(mk(0, 1,1, 0,0, 0,0,   1,40,41, 2, 0, 0));
    tv.push_back(mk(0, 0,0, 1,50, 0,0,  0,-1,-1, 0, 1, 0));
    tv.push_back(mk(0, 0,0, 1,50, 0,0,  0,50,-1, 1, 0, 0));
    tv.push_back(mk(0, 0,0, 0,0, 0,0,   0,50,-1, 1, 0, 1));
    tv.push_back(mk(0, 1,1, 0,0, 0,0,   0,50,-1, 1, 0, 1));
    tv.push_back(mk(1, 0,0, 0,0, 0,0,  -1,-1,-1,-1,-1,-1));
    tv.push_back(mk(0, 1,1, 0,0, 0,0,   1,32,33,32, 0, 0));
    tv.push_back(mk(0, 0,0, 1,33, 1,33, 0,34,35,30, 0, 0));
    tv.push_back(mk(0, 0,0, 0,0, 0,0,   0,34,35,31, 0, 1));
    tv.push_back(mk(1, 1,1, 1,40, 1,41,-1,-1,-1,-1,-1,-1));
    tv.push_back(mk(0, 0,0, 1,0, 1,0,   0,32,33,32, 0, 0));
    tv.push_back(mk(0, 0,0, 0,0, 0,0,   0,32,33,32, 0, 0));
    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i].rs, tv[i].r1, tv[i].r2, tv[i].f1, tv[i].p1, tv[i].f2, tv[i].p2);
      #1;
      chk($sformatf("v%0d.ok", i),  int'(alloc_ok),     tv[i].ok);
      chk($sformatf("v%0d.pd1", i), int'(alloc_pd_1),   tv[i].pd1);
      chk($sformatf("v%0d.pd2", i), int'(alloc_pd_2),   tv[i].pd2);
      chk($sformatf("v%0d.cnt", i), int'(free_count),   tv[i].cnt);
      chk($sformatf("v%0d.emp", i), int'(empty),        tv[i].emp);
      chk($sformatf("v%0d.err", i), int'(dbl_free_err), tv[i].err);
    end
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    q.delete();
    held.delete();
    for (int p = 32; p < 64; p++) q.push_back(p);
    for (int c = 0; c < 160; c++) begin
      bit r1, r2, f1, f2, g;
      int p1, p2, n;
      @(negedge clk);
      r1 = c < 100 ? c % 2 == 0 : 1'($urandom);
      r2 = c < 100 ? r1 : 1'($urandom);
      f1 = 0; f2 = 0; p1 = 0; p2 = 0;
      if (c < 100 ? (c % 2 == 1 && held.size() >= 2) : held.size() > 0 && 1'($urandom)) begin
        f1 = 1; p1 = held.pop_front();
      end
      if (c < 100 ? f1 : held.size() > 0 && 1'($urandom)) begin
        f2 = 1; p2 = held.pop_front();
      end
      drive(0, r1, r2, f1, p1, f2, p2);
      #1;
      n = r1 ? (r2 ? 2 : 1) : 0;
      g = n != 0 && q.size() >= n;
      chk($sformatf("s%0d.cnt", c), int'(free_count), q.size());
      chk($sformatf("s%0d.ok", c),  int'(alloc_ok),   int'(g));
      if (g) begin
        int g1;
        g1 = q.pop_front();
        chk($sformatf("s%0d.pd1", c), int'(alloc_pd_1), g1);
        if (n == 2) begin
          int g2;
          g2 = q.pop_front();
          chk($sformatf("s%0d.pd2", c), int'(alloc_pd_2), g2);
          held.push_back(g2);
        end
        if (c >= 100 && !f2 && $urandom_range(0, 3) == 0) begin
          f2 = 1; p2 = g1;
          drive(0, r1, r2, f1, p1, f2, p2);
        end else held.push_back(g1);
      end
      if (f1) q.push_back(p1);
      if (f2) q.push_back(p2);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("final.cnt", int'(free_count), q.size());
    chk("final.err", int'(dbl_free_err), 0);
    if (q.size() > 0) chk("final.pd1", int'(alloc_pd_1), q[0]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 Parameter NUM_PREGS, default 64, physical register count; FIFO depth equals NUM_PREGS.
REQ-002 Parameter NUM_AREGS, default 32, architectural register count; pregs 0..NUM_AREGS-1 are architecturally mapped at reset.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 alloc_req_1  in  1  rename requests first destination preg this cycle.
REQ-006 alloc_req_2  in  1  rename requests second destination preg; honoured only with alloc_req_1.
REQ-007 alloc_pd_1  out  6  preg granted to request 1 (FIFO head).
REQ-008 alloc_pd_2  out  6  preg granted to request 2 (head+1).
REQ-009 alloc_ok  out  1  requested pregs available; pop occurs at next edge.
REQ-010 rt_flag_1  in  1  retire slot 1 releases a preg.
REQ-011 fp_i_1  in  6  old preg released by retire slot 1.
REQ-012 rt_flag_2  in  1  retire slot 2 releases a preg.
REQ-013 fp_i_2  in  6  old preg released by retire slot 2.
REQ-014 free_count  out  7  number of free pregs held, 0..64.
REQ-015 empty  out  1  free_count == 0.
REQ-016 dbl_free_err  out  1  sticky error: release of a preg already free.

Function
REQ-017 Storage: 64-entry circular FIFO of 6-bit preg ids, 6-bit head/tail pointers wrapping 63->0 naturally, 7-bit count, 64-bit free_vec (bit n = preg n in FIFO).
REQ-018 alloc_pd_1 = fifo[head], alloc_pd_2 = fifo[head+1 mod 64], combinational, driven regardless of requests.
REQ-019 nreq = 2 if alloc_req_1 & alloc_req_2; 1 if alloc_req_1 only; 0 otherwise (alloc_req_2 alone ignored).
REQ-020 alloc_ok = (nreq != 0) & (count >= nreq), combinational, all-or-nothing: no partial grant when count == 1 and nreq == 2.
REQ-021 On edge with alloc_ok: head += nreq, clear free_vec bits of granted pregs.
REQ-022 Release slot k accepted iff rt_flag_k & fp_i_k != 0 & free_vec[fp_i_k] == 0 (after slot 1 update for slot 2).
REQ-023 Accepted releases written at tail in order slot 1 then slot 2; tail += nacc; free_vec bits set.
REQ-024 fp_i_k == 0 with rt_flag_k: silently dropped, no error (p0 permanent for x0).
REQ-025 rt_flag_k with free_vec[fp_i_k] == 1: dropped, dbl_free_err set to 1 and held until rst.
REQ-026 Slots 1 and 2 releasing the same preg in one cycle: slot 1 accepted, slot 2 treated as double free.
REQ-027 Simultaneous alloc and release: count_next = count - (alloc_ok ? nreq : 0) + nacc; alloc_ok uses pre-edge count only.
REQ-028 No release-to-alloc bypass: a preg released at edge N is grantable no earlier than cycle after edge N.
REQ-029 A preg granted at edge N may be released at the same or later edge; no corruption of FIFO order.
REQ-030 count never exceeds 64: guaranteed by free_vec check; no overflow path exists.
REQ-031 Empty with nreq != 0: alloc_ok = 0, head unchanged, releases still accepted that cycle.

Reset
REQ-032 rst at edge: fifo[i] = NUM_AREGS + i for i = 0..31, head = 0, tail = 32, count = 32, free_vec = 1 for pregs 32..63 only, dbl_free_err = 0.
REQ-033 After reset: alloc_pd_1 = 32, alloc_pd_2 = 33, free_count = 32, empty = 0, alloc_ok = 0 unless requests asserted.
REQ-034 rst overrides all concurrent requests and releases in the same cycle; mid-operation reset discards in-flight grants and releases.

Verification
REQ-035 Reset then alloc_req_1 & alloc_req_2 one cycle -> alloc_ok = 1, pds 32/33; next cycle pds 34/35, free_count 30.
REQ-036 Drain 31 pregs, then dual request with count 1 -> alloc_ok = 0, head unchanged; single request -> grant 63, empty = 1.
REQ-037 From empty, release preg 40 on slot 1 and 41 on slot 2 with dual request same cycle -> alloc_ok = 0; next cycle pds 40/41, alloc_ok = 1.
REQ-038 Release preg 50 while still free -> dbl_free_err = 1, free_count unchanged; stays 1 until rst.
REQ-039 Both slots release preg 33 (allocated) same cycle -> count +1, dbl_free_err = 1; rt_flag with fp_i = 0 -> no change, no error.
REQ-040 100 cycles alternating dual alloc / dual release of returned pregs -> pointers wrap past 63 with no lost or duplicated preg; free_count stays consistent with free_vec popcount.
